interrupt_controller: RTL and testbench

//  Receiving end of the timer preemption signal: accepts the quantum-expiry sigint from the clock

---
 rtl/interrupt_pkg.sv | 22 ++
 rtl/irq_priority_encoder.sv | 23 ++
 rtl/interrupt_controller.sv | 161 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and helpers for the interrupt controller: FSM states, the timer
// cause code and the cause-to-handler-vector mapping.
package interrupt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        TAKE,
        HANDLER,
        RETURN
    } irq_state_t;

    localparam int CAUSE_TIMER = 0;

    // Callers truncate the result to their PC width; 64-bit math then wraps correctly.
    function automatic logic [63:0] cause_to_vector(input logic [63:0] base,
                                                    input logic [63:0] stride,
                                                    input logic [7:0]  cause_code);
        return base + stride * {56'd0, cause_code};
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority pick over {ext lines, timer}: bit 0 is the timer
// (lowest priority), bit i+1 is ext_irq[i], with ext_irq[0] the highest.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int CAUSE_W = $clog2(NUM_IRQ + 1)
) (
    input  logic [NUM_IRQ:0]   req,
    output logic               any,
    output logic [CAUSE_W-1:0] cause
);

    always_comb begin
        any   = |req;
        cause = '0;
        // Scan downward so the lowest-numbered external line wins.
        for (int i = NUM_IRQ; i >= 1; i--) begin
            if (req[i]) begin
                cause = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Takes the timer quantum-expiry or an external request at an instruction boundary,
// saves the PC, redirects fetch to the handler vector and restores it on iret.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int               NUM_IRQ       = 4,
    parameter int               PC_W          = 32,
    parameter logic [PC_W-1:0]  VECTOR_BASE   = 'h100,
    parameter int               VECTOR_STRIDE = 16,
    localparam int              CAUSE_W       = $clog2(NUM_IRQ + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sigint,
    input  logic [NUM_IRQ-1:0]  ext_irq,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic                int_enable,
    input  logic                instr_boundary,
    input  logic [PC_W-1:0]     pc_current,
    input  logic                iret,
    output logic                pc_redirect_valid,
    output logic [PC_W-1:0]     pc_redirect,
    output logic [PC_W-1:0]     epc,
    output logic [CAUSE_W-1:0]  cause,
    output logic [NUM_IRQ-1:0]  ack_ext,
    output logic                in_handler,
    output logic                timer_stop,
    output logic                timer_reset
);

    irq_state_t          state_reg, state_next;
    logic [CAUSE_W-1:0]  cause_reg, cause_next;
    logic [PC_W-1:0]     epc_reg, epc_next;
    logic [PC_W-1:0]     pc_redirect_reg, pc_redirect_next;
    logic                redirect_valid_reg, redirect_valid_next;
    logic [NUM_IRQ-1:0]  ack_reg, ack_next;
    logic                in_handler_reg, in_handler_next;
    logic                timer_stop_reg, timer_stop_next;
    logic                timer_reset_reg, timer_reset_next;
    logic                guard_reg, guard_next;

    logic [NUM_IRQ:0]    req;
    logic                req_any;
    logic [CAUSE_W-1:0]  req_cause;

    // The timer needs one cycle after its reset pulse to drop sigint, hence the guard.
    assign req[0] = sigint & ~guard_reg;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_req
            assign req[gi+1] = ext_irq[gi] & irq_mask[gi];
        end
    endgenerate

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .req   (req),
        .any   (req_any),
        .cause (req_cause)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            cause_reg          <= '0;
            epc_reg            <= '0;
            pc_redirect_reg    <= '0;
            redirect_valid_reg <= 1'b0;
            ack_reg            <= '0;
            in_handler_reg     <= 1'b0;
            timer_stop_reg     <= 1'b0;
            timer_reset_reg    <= 1'b0;
            guard_reg          <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cause_reg          <= cause_next;
            epc_reg            <= epc_next;
            pc_redirect_reg    <= pc_redirect_next;
            redirect_valid_reg <= redirect_valid_next;
            ack_reg            <= ack_next;
            in_handler_reg     <= in_handler_next;
            timer_stop_reg     <= timer_stop_next;
            timer_reset_reg    <= timer_reset_next;
            guard_reg          <= guard_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        cause_next          = cause_reg;
        epc_next            = epc_reg;
        pc_redirect_next    = pc_redirect_reg;
        redirect_valid_next = 1'b0;
        ack_next            = '0;
        in_handler_next     = in_handler_reg;
        timer_stop_next     = timer_stop_reg;
        timer_reset_next    = 1'b0;
        guard_next          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (int_enable && req_any) begin
                    state_next = PENDING;
                    cause_next = req_cause;
                end
            end
            PENDING: begin
                if (!int_enable || !req_any) begin
                    state_next = IDLE;
                end else begin
                    cause_next = req_cause;
                    if (instr_boundary) begin
                        epc_next   = pc_current;
                        state_next = TAKE;
                    end
                end
            end
            TAKE: begin
                pc_redirect_next    = PC_W'(cause_to_vector(64'(VECTOR_BASE),
                                                            64'(VECTOR_STRIDE),
                                                            8'(cause_reg)));
                redirect_valid_next = 1'b1;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    ack_next[i] = (cause_reg == CAUSE_W'(i + 1));
                end
                timer_stop_next     = 1'b1;
                in_handler_next     = 1'b1;
                state_next          = HANDLER;
            end
            HANDLER: begin
                if (iret) begin
                    state_next = RETURN;
                end
            end
            RETURN: begin
                pc_redirect_next    = epc_reg;
                redirect_valid_next = 1'b1;
                timer_reset_next    = 1'b1;
                timer_stop_next     = 1'b0;
                in_handler_next     = 1'b0;
                guard_next          = 1'b1;
                state_next          = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pc_redirect_valid = redirect_valid_reg;
    assign pc_redirect       = pc_redirect_reg;
    assign epc               = epc_reg;
    assign cause             = cause_reg;
    assign ack_ext           = ack_reg;
    assign in_handler        = in_handler_reg;
    assign timer_stop        = timer_stop_reg;
    assign timer_reset       = timer_reset_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: take/return timing, priority,
// guard after return, global disable, masking and asynchronous reset.
module tb_interrupt_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sigint = 1'b0;
    logic [3:0]  ext_irq = '0;
    logic [3:0]  irq_mask = '0;
    logic        int_enable = 1'b0;
    logic        instr_boundary = 1'b0;
    logic [31:0] pc_current = '0;
    logic        iret = 1'b0;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic [3:0]  ack_ext;
    logic        in_handler;
    logic        timer_stop;
    logic        timer_reset;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    interrupt_controller dut (
        .clock             (clock),
        .reset             (reset),
        .sigint            (sigint),
        .ext_irq           (ext_irq),
        .irq_mask          (irq_mask),
        .int_enable        (int_enable),
        .instr_boundary    (instr_boundary),
        .pc_current        (pc_current),
        .iret              (iret),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .epc               (epc),
        .cause             (cause),
        .ack_ext           (ack_ext),
        .in_handler        (in_handler),
        .timer_stop        (timer_stop),
        .timer_reset       (timer_reset)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Take path from IDLE with requests already driven: edge -> PENDING,
    // boundary edge -> TAKE, next edge -> redirect visible.
    task automatic enter_handler(input logic [31:0] pc);
        pc_current = pc;
        tick();
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tick();
    endtask

    task automatic do_return(input string tag, input logic [31:0] exp_pc);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        check({tag, "_iret_no_early_redirect"}, 64'(pc_redirect_valid), 64'd0);
        tick();
        check({tag, "_ret_valid"}, 64'(pc_redirect_valid), 64'd1);
        check({tag, "_ret_pc"}, 64'(pc_redirect), 64'(exp_pc));
        check({tag, "_ret_timer_reset"}, 64'(timer_reset), 64'd1);
        check({tag, "_ret_in_handler"}, 64'(in_handler), 64'd0);
        check({tag, "_ret_timer_stop"}, 64'(timer_stop), 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(pc_redirect_valid), 64'd0);
        check("rst_epc", 64'(epc), 64'd0);
        check("rst_cause", 64'(cause), 64'd0);
        check("rst_in_handler", 64'(in_handler), 64'd0);
        check("rst_timer_stop", 64'(timer_stop), 64'd0);
        reset = 1'b1;
        irq_mask = 4'hF;
        tick();

        // 1: timer take and return
        sigint = 1'b1;
        int_enable = 1'b1;
        enter_handler(32'h40);
        check("t1_valid", 64'(pc_redirect_valid), 64'd1);
        check("t1_vector", 64'(pc_redirect), 64'h100);
        check("t1_epc", 64'(epc), 64'h40);
        check("t1_cause", 64'(cause), 64'd0);
        check("t1_timer_stop", 64'(timer_stop), 64'd1);
        check("t1_in_handler", 64'(in_handler), 64'd1);
        check("t1_ack", 64'(ack_ext), 64'd0);
        sigint = 1'b0;
        tick();
        check("t1_valid_pulse_end", 64'(pc_redirect_valid), 64'd0);
        do_return("t1", 32'h40);
        tick();
        check("t1_timer_reset_pulse_end", 64'(timer_reset), 64'd0);

        // 2: ext_irq[2] beats the timer
        ext_irq = 4'b0100;
        sigint = 1'b1;
        enter_handler(32'h80);
        check("t2_cause", 64'(cause), 64'd3);
        check("t2_vector", 64'(pc_redirect), 64'h130);
        check("t2_ack", 64'(ack_ext), 64'b0100);
        ext_irq = '0;
        sigint = 1'b0;
        tick();
        check("t2_ack_pulse_end", 64'(ack_ext), 64'd0);
        do_return("t2", 32'h80);
        tick();

        // 3: higher-priority arrival while pending replaces the cause
        sigint = 1'b1;
        pc_current = 32'hC0;
        tick();
        check("t3_pending_cause_timer", 64'(cause), 64'd0);
        ext_irq = 4'b0001;
        tick();
        check("t3_pending_cause_ext0", 64'(cause), 64'd1);
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        tick();
        check("t3_vector", 64'(pc_redirect), 64'h110);
        check("t3_ack", 64'(ack_ext), 64'b0001);
        ext_irq = '0;
        sigint = 1'b0;
        tick();
        do_return("t3", 32'hC0);
        tick();

        // 4: sigint held through return; guard delays the retake by one cycle
        sigint = 1'b1;
        enter_handler(32'h200);
        check("t4_vector", 64'(pc_redirect), 64'h100);
        tick();
        do_return("t4", 32'h200);
        instr_boundary = 1'b1;
        pc_current = 32'h300;
        tick();
        tick();
        tick();
        check("t4_no_retake_in_guard", 64'(pc_redirect_valid), 64'd0);
        check("t4_not_in_handler", 64'(in_handler), 64'd0);
        tick();
        instr_boundary = 1'b0;
        check("t4_retake_valid", 64'(pc_redirect_valid), 64'd1);
        check("t4_retake_vector", 64'(pc_redirect), 64'h100);
        check("t4_retake_epc", 64'(epc), 64'h300);
        sigint = 1'b0;
        tick();
        do_return("t4b", 32'h300);
        tick();

        // 5: global disable and per-line masking block everything
        int_enable = 1'b0;
        sigint = 1'b1;
        ext_irq = 4'hF;
        instr_boundary = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t5_disabled_valid_%0d", i), 64'(pc_redirect_valid), 64'd0);
            check($sformatf("t5_disabled_in_handler_%0d", i), 64'(in_handler), 64'd0);
        end
        int_enable = 1'b1;
        sigint = 1'b0;
        ext_irq = 4'b0001;
        irq_mask = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_masked_valid_%0d", i), 64'(pc_redirect_valid), 64'd0);
        end
        instr_boundary = 1'b0;
        ext_irq = '0;
        irq_mask = 4'hF;
        tick();

        // 6: asynchronous reset in the handler
        sigint = 1'b1;
        enter_handler(32'h500);
        check("t6_in_handler_before", 64'(in_handler), 64'd1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_in_handler", 64'(in_handler), 64'd0);
        check("t6_async_timer_stop", 64'(timer_stop), 64'd0);
        check("t6_async_epc", 64'(epc), 64'd0);
        check("t6_async_valid", 64'(pc_redirect_valid), 64'd0);
        sigint = 1'b0;
        int_enable = 1'b0;
        tick();
        reset = 1'b1;
        iret = 1'b1;
        tick();
        iret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_iret_ignored_valid_%0d", i), 64'(pc_redirect_valid), 64'd0);
            check($sformatf("t6_iret_ignored_treset_%0d", i), 64'(timer_reset), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
